// File: rtl/usb_rx_crc16_depacketizer_pkg.sv
// Shared constants, state encoding and PID helpers for the USB receive
// depacketizer.
package usb_rx_pkg;

    // DATA-class PID low nibbles.
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;

    // CRC16 as used on the USB data field. The register shifts MSB-first
    // while the wire bits arrive LSB-first. A clean packet, including the
    // inverted CRC field, leaves the fixed residual in the register.
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PID  = 3'd1,
        ST_DATA = 3'd2,
        ST_SKIP = 3'd3,
        ST_DONE = 3'd4
    } rx_state_t;

    // A DATA PID is any PID whose low two bits are 2'b11.
    function automatic logic is_data_pid(input logic [3:0] p);
        return (p == PID_DATA0) || (p == PID_DATA1) ||
               (p == PID_DATA2) || (p == PID_MDATA);
    endfunction

    // The upper nibble of a PID byte must be the complement of the lower nibble.
    function automatic logic pid_check_err(input logic [7:0] b);
        return b[7:4] != ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_crc16_depacketizer_if.sv
// Bus bundle between the bit-serial receive front end and the endpoint-side
// byte consumer.
//
// Handshake: when out_valid is high, out_data is stable and held until a
// cycle with out_valid & out_ready, when the byte is transferred on the clock
// edge. out_valid never drops without a transfer, and the consumer may raise
// out_ready at any time. rx_bit is sampled only when rx_valid & rx_active.
// There is no back-pressure on the serial side.
interface usb_rx_crc16_depacketizer_if;
    import usb_rx_pkg::*;

    logic       rx_active;
    logic       rx_valid;
    logic       rx_bit;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pid;
    logic       pkt_done;
    logic       is_data;
    logic       pid_err;
    logic       crc_err;
    logic       len_err;
    logic       overflow;

    // Environment side: the bit source plus the byte consumer.
    modport master (
        output rx_active, rx_valid, rx_bit, out_ready,
        input  out_data, out_valid, pid, pkt_done, is_data,
        input  pid_err, crc_err, len_err, overflow
    );

    // Depacketizer side.
    modport slave (
        input  rx_active, rx_valid, rx_bit, out_ready,
        output out_data, out_valid, pid, pkt_done, is_data,
        output pid_err, crc_err, len_err, overflow
    );

endinterface

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 LFSR. i_init reloads the initial value. i_enable folds in
// one bit per cycle.
module usb_crc16_serial
    import usb_rx_pkg::*;
(
    input  logic        clk_c,
    input  logic        reset,
    input  logic        i_init,
    input  logic        i_enable,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb  = i_bit ^ r_crc[15];
    assign o_crc = r_crc;

    // LFSR register: reload on reset or init, otherwise shift when enabled.
    always_ff @(posedge clk_c) begin
        if (reset || i_init) begin
            r_crc <= CRC16_INIT;
        end else if (i_enable) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_rx_crc16_depacketizer.sv
// USB receive depacketizer: assembles PID and payload bytes from the
// unstuffed bit stream, checks the PID and the CRC16 residual, and forwards
// payload bytes with the two CRC bytes stripped. A two-deep byte pipe delays
// emission by two bytes, so the CRC bytes are still in the pipe at EOP and
// are simply discarded.
module usb_rx_crc16_depacketizer
    import usb_rx_pkg::*;
(
    input  logic                         clk_c,
    input  logic                         reset,
    usb_rx_crc16_depacketizer_if.slave   bus,
    output rx_state_t                    o_dbg_state
);

    rx_state_t   r_state;
    rx_state_t   w_next;

    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [1:0]  r_pipe_cnt;
    logic [3:0]  r_pid;
    logic        r_pid_err;
    logic        r_is_data;
    logic        r_crc_err;
    logic        r_len_err;
    logic        r_ovf;
    logic [7:0]  r_out_data;
    logic        r_out_valid;

    logic        w_in_pkt;
    logic        w_bit_ev;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic        w_pid_err;
    logic        w_eop;
    logic        w_emit;
    logic        w_crc_init;
    logic        w_crc_en;
    logic [15:0] w_crc;
    logic        w_pkt_done;
    logic        w_aligned;

    // Packet-open states are the ones that consume bits and watch for EOP.
    assign w_in_pkt    = (r_state == ST_PID) || (r_state == ST_DATA) ||
                         (r_state == ST_SKIP);
    assign w_bit_ev    = w_in_pkt && bus.rx_active && bus.rx_valid;
    assign w_eop       = w_in_pkt && !bus.rx_active;
    assign w_byte      = {bus.rx_bit, r_shift};
    assign w_byte_done = w_bit_ev && (r_bit_cnt == 3'd7);
    assign w_pid_err   = pid_check_err(w_byte);
    assign w_emit      = (r_state == ST_DATA) && w_byte_done &&
                         (r_pipe_cnt == 2'd2);
    assign w_crc_init  = (r_state == ST_IDLE);
    assign w_crc_en    = (r_state == ST_DATA) && w_bit_ev;
    assign w_aligned   = (r_bit_cnt == 3'd0);

    usb_crc16_serial u_crc (
        .clk_c    (clk_c),
        .reset    (reset),
        .i_init   (w_crc_init),
        .i_enable (w_crc_en),
        .i_bit    (bus.rx_bit),
        .o_crc    (w_crc)
    );

    // State register.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and the status strobe.
    always_comb begin
        w_next     = r_state;
        w_pkt_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_active) w_next = ST_PID;
            end
            ST_PID: begin
                if (!bus.rx_active) begin
                    w_next = ST_DONE;
                end else if (w_byte_done) begin
                    w_next = (is_data_pid(w_byte[3:0]) && !w_pid_err) ?
                             ST_DATA : ST_SKIP;
                end
            end
            ST_DATA, ST_SKIP: begin
                if (!bus.rx_active) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_pkt_done = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Bit assembly, PID capture, byte pipe and EOP flag evaluation.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_b0       <= 8'd0;
            r_b1       <= 8'd0;
            r_pipe_cnt <= 2'd0;
            r_pid      <= 4'd0;
            r_pid_err  <= 1'b0;
            r_is_data  <= 1'b0;
            r_crc_err  <= 1'b0;
            r_len_err  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_b0       <= 8'd0;
            r_b1       <= 8'd0;
            r_pipe_cnt <= 2'd0;
            r_pid_err  <= 1'b0;
            r_is_data  <= 1'b0;
            r_crc_err  <= 1'b0;
            r_len_err  <= 1'b0;
        end else if (w_eop) begin
            r_is_data <= (r_state != ST_PID) && is_data_pid(r_pid);
            case (r_state)
                ST_PID: begin
                    r_len_err <= 1'b1;
                    r_crc_err <= 1'b0;
                end
                ST_DATA: begin
                    r_len_err <= !w_aligned || (r_pipe_cnt != 2'd2);
                    r_crc_err <= w_aligned && (r_pipe_cnt == 2'd2) &&
                                 (w_crc != CRC16_RESIDUAL);
                end
                default: begin
                    r_len_err <= !w_aligned;
                    r_crc_err <= 1'b0;
                end
            endcase
        end else if (w_bit_ev) begin
            r_shift   <= w_byte[7:1];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done && (r_state == ST_PID)) begin
                r_pid     <= w_byte[3:0];
                r_pid_err <= w_pid_err;
            end
            if (w_byte_done && (r_state == ST_DATA)) begin
                case (r_pipe_cnt)
                    2'd0: begin
                        r_b0       <= w_byte;
                        r_pipe_cnt <= 2'd1;
                    end
                    2'd1: begin
                        r_b1       <= w_byte;
                        r_pipe_cnt <= 2'd2;
                    end
                    default: begin
                        r_b0 <= r_b1;
                        r_b1 <= w_byte;
                    end
                endcase
            end
        end
    end

    // Output byte register. A byte emitted while the previous one is held
    // and not being accepted is dropped and marks the packet as overflowed.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_emit) begin
                if (r_out_valid && !bus.out_ready) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_out_data  <= r_b0;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == ST_IDLE) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.pid       = r_pid;
    assign bus.pkt_done  = w_pkt_done;
    assign bus.is_data   = w_pkt_done & r_is_data;
    assign bus.pid_err   = w_pkt_done & r_pid_err;
    assign bus.crc_err   = w_pkt_done & r_crc_err;
    assign bus.len_err   = w_pkt_done & r_len_err;
    assign bus.overflow  = w_pkt_done & r_ovf;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_usb_rx_crc16_depacketizer.sv
// Directed bench for the USB receive depacketizer. Expected payload bytes and
// per-packet status are queued as stimulus is driven, and are popped when the
// DUT hands a byte over or pulses pkt_done.
module tb_usb_rx_crc16_depacketizer;
    import usb_rx_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_c = 1'b0;
    logic reset;
    always #5 clk_c = ~clk_c;

    usb_rx_crc16_depacketizer_if bus();
    rx_state_t dbg_state;

    usb_rx_crc16_depacketizer dut (
        .clk_c       (clk_c),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    // {pid[3:0], is_data, pid_err, crc_err, len_err, overflow}
    logic [8:0] exp_st_q[$];
    logic [7:0] pay[8];

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then return just after
    // the next rising edge so the caller can drive new inputs.
    task automatic cyc();
        logic [7:0] eb;
        logic [8:0] es;
        @(negedge clk_c);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("byte_expected", 16'(exp_q.size() != 0), 16'd1);
            end else begin
                eb = exp_q.pop_front();
                check("out_data", 16'(bus.out_data), 16'(eb));
            end
        end
        if (bus.pkt_done) begin
            if (exp_st_q.size() == 0) begin
                check("pkt_done_expected", 16'(exp_st_q.size() != 0), 16'd1);
            end else begin
                es = exp_st_q.pop_front();
                check("pid",      16'(bus.pid),      16'(es[8:5]));
                check("is_data",  16'(bus.is_data),  16'(es[4]));
                check("pid_err",  16'(bus.pid_err),  16'(es[3]));
                check("crc_err",  16'(bus.crc_err),  16'(es[2]));
                check("len_err",  16'(bus.len_err),  16'(es[1]));
                check("overflow", 16'(bus.overflow), 16'(es[0]));
            end
        end
        @(posedge clk_c);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] crc16_upd(input logic [15:0] c,
                                              input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = b[i] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc_of(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) c = crc16_upd(c, pay[i]);
        return c;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b);
        int gap;
        bus.rx_active = 1'b1;
        bus.rx_valid  = 1'b1;
        bus.rx_bit    = b;
        cyc();
        bus.rx_valid  = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    // CRC field goes out inverted, register MSB first.
    task automatic send_crc(input logic [15:0] c);
        for (int i = 15; i >= 0; i--) send_bit(~c[i]);
    endtask

    task automatic start_pkt();
        bus.rx_active = 1'b1;
        bus.rx_valid  = 1'b0;
        cyc();
    endtask

    task automatic end_pkt();
        bus.rx_active = 1'b0;
        bus.rx_valid  = 1'b0;
        repeat (6) cyc();
        check("bytes_left", 16'(exp_q.size()), 16'd0);
        check("status_left", 16'(exp_st_q.size()), 16'd0);
    endtask

    task automatic send_data(input logic [7:0] pid8, input int n,
                             input logic [15:0] crc, input logic push);
        start_pkt();
        send_byte(pid8);
        for (int i = 0; i < n; i++) begin
            if (push) exp_q.push_back(pay[i]);
            send_byte(pay[i]);
        end
        send_crc(crc);
    endtask

    task automatic check_reset_vals();
        check("rst_out_data",  16'(bus.out_data),  16'd0);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_pid",       16'(bus.pid),       16'd0);
        check("rst_pkt_done",  16'(bus.pkt_done),  16'd0);
        check("rst_is_data",   16'(bus.is_data),   16'd0);
        check("rst_pid_err",   16'(bus.pid_err),   16'd0);
        check("rst_crc_err",   16'(bus.crc_err),   16'd0);
        check("rst_len_err",   16'(bus.len_err),   16'd0);
        check("rst_overflow",  16'(bus.overflow),  16'd0);
        check("rst_state",     16'(dbg_state),     16'(ST_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] c;
        int          n;
        reset         = 1'b1;
        bus.rx_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_bit    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        check_reset_vals();
        reset = 1'b0;
        cyc();

        // DATA0 with 4-byte payload, consumer always ready.
        pay[0] = 8'h00; pay[1] = 8'h01; pay[2] = 8'h02; pay[3] = 8'h03;
        exp_st_q.push_back({4'h3, 5'b10000});
        send_data(8'hC3, 4, crc_of(4), 1'b1);
        end_pkt();

        // Zero-length DATA1.
        exp_st_q.push_back({4'hB, 5'b10000});
        send_data(8'h4B, 0, crc_of(0), 1'b1);
        end_pkt();

        // Same DATA0 with one payload bit flipped after the CRC was computed.
        pay[0] = 8'h00; pay[1] = 8'h01; pay[2] = 8'h02; pay[3] = 8'h03;
        c = crc_of(4);
        pay[2] = pay[2] ^ 8'h04;
        exp_st_q.push_back({4'h3, 5'b10100});
        send_data(8'hC3, 4, c, 1'b1);
        end_pkt();

        // ACK handshake.
        exp_st_q.push_back({4'h2, 5'b00000});
        start_pkt();
        send_byte(8'hD2);
        end_pkt();

        // Corrupted PID byte.
        exp_st_q.push_back({4'h2, 5'b01000});
        start_pkt();
        send_byte(8'hC2);
        end_pkt();

        // DATA0 ending 3 bits into a byte.
        exp_st_q.push_back({4'h3, 5'b10010});
        start_pkt();
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        end_pkt();

        // Reset in the middle of a payload: no status must follow.
        start_pkt();
        send_byte(8'hC3);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1;
        cyc();
        cyc();
        check_reset_vals();
        bus.rx_active = 1'b0;
        reset = 1'b0;
        end_pkt();

        // 6-byte DATA0 with the consumer stalled: first byte held, rest dropped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pay[i] = 8'($urandom_range(0, 255));
        exp_st_q.push_back({4'h3, 5'b10001});
        send_data(8'hC3, 6, crc_of(6), 1'b0);
        end_pkt();
        check("held_valid", 16'(bus.out_valid), 16'd1);
        check("held_data", 16'(bus.out_data), 16'(pay[0]));
        exp_q.push_back(pay[0]);
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        check("held_drained", 16'(exp_q.size()), 16'd0);

        // Random-length good DATA1 with random payload.
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
        exp_st_q.push_back({4'hB, 5'b10000});
        send_data(8'h4B, n, crc_of(n), 1'b1);
        end_pkt();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/usb_rx_crc16_depacketizer.md
# usb_rx_crc16_depacketizer

Receive-side USB packet depacketizer. Its input is the bit-serial stream after NRZI decode and bit unstuffing. It assembles the PID and payload bytes LSB-first, checks the PID, and runs a CRC16 residual check over the data field. It forwards payload bytes, with the two CRC bytes stripped, to the endpoint logic over a valid/ready byte interface, and reports per-packet status at EOP.

## Interface
- No parameters.
- `clk_c` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_active` in 1: high from the first bit after SYNC through the last bit. A low level while a packet is open means EOP.
- `rx_valid` in 1: qualifies `rx_bit` for one cycle. Ignored when `rx_active` = 0.
- `rx_bit` in 1: serial data, LSB-first.
- `out_data` out 8: payload byte.
- `out_valid` out 1: byte available. Held until accepted.
- `out_ready` in 1: consumer accepts the byte when `out_valid` & `out_ready`.
- `pid` out 4: captured PID[3:0]. Valid from PID completion until the next packet starts.
- `pkt_done` out 1: one-cycle status strobe after EOP.
- `is_data` out 1: packet carried a DATA PID (PID[1:0] = 2'b11). Qualified by `pkt_done`.
- `pid_err` out 1: PID[7:4] != ~PID[3:0]. Qualified by `pkt_done`.
- `crc_err` out 1: data packet whose CRC residual != 16'h800D. Qualified by `pkt_done`.
- `len_err` out 1: EOP not byte-aligned, EOP before the PID is complete, or a data packet with fewer than 2 post-PID bytes. Qualified by `pkt_done`.
- `overflow` out 1: at least one byte was dropped because the output was still held. Qualified by `pkt_done`.

## Operation
- States: IDLE, PID, DATA, SKIP, DONE.
- **IDLE:**
  - Clears the bit counter, the CRC register (to 16'hFFFF), the byte pipe and all error flags.
  - `rx_active` = 1 → PID.
- **PID:**
  - Shifts 8 valid bits into the PID register.
  - On the 8th bit, compute `pid_err`.
  - If PID[1:0] = 2'b11 and `pid_err` = 0 → DATA. Otherwise → SKIP.
- **DATA:**
  - Every valid bit updates the CRC: feedback = `rx_bit` ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (feedback ? 16'h8005 : 0).
  - Every 8th bit completes a byte into a 2-deep pipe (b0 oldest, b1).
  - When a byte completes with the pipe full, b0 is emitted, b1 moves to b0, and the new byte goes to b1.
  - At EOP the two bytes left in the pipe are the CRC and are discarded.
- **SKIP:**
  - Non-data packets (tokens, handshakes, SOF) and PID-error packets are consumed without emitting bytes.
  - Only bit alignment is tracked, for `len_err`. Token CRC5 is checked elsewhere.
- EOP (`rx_active` = 0 in PID, DATA or SKIP) → DONE. Flags are evaluated from the state held at EOP.
- **DONE:**
  - `pkt_done` = 1 for exactly one cycle, then → IDLE.
  - `crc_err` is evaluated only for byte-aligned data packets with ≥2 post-PID bytes. Otherwise `crc_err` = 0.
- Output register:
  - An emitted byte loads `out_data` and sets `out_valid`.
  - If `out_valid` & ~`out_ready` when a new byte is emitted, the new byte is dropped, the held byte is kept, and `overflow` is set (sticky until IDLE).
  - A byte emitted in the same cycle as acceptance is not an overflow.
- `rx_active` must be low for ≥1 cycle between packets. Bits arriving while in DONE are ignored.
- Reset mid-packet: all state is cleared to IDLE. A packet in progress is lost and produces no `pkt_done`.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `pid` = 0, `pkt_done` = 0, `is_data` = 0, all error flags 0, state IDLE.
- Byte emission: `out_valid` rises on the cycle after the sampled 8th bit of the 3rd, 4th, … post-PID byte.
- EOP latency: `rx_active` low sampled at edge N → DONE at N+1, with `pkt_done` and all flags high during cycle N+1.
- `out_valid` is independent of `pkt_done`. The last payload byte may still be held when `pkt_done` pulses.
- Bit rate is at most one `rx_valid` per cycle.

## Structure
- `usb_rx_pkg` holds:
  - PID constants (DATA0 4'b0011, DATA1 4'b1011, DATA2 4'b0111, MDATA 4'b1111).
  - CRC16_POLY 16'h8005, CRC16_INIT 16'hFFFF, CRC16_RESIDUAL 16'h800D.
  - State enum.
- One sub-module, `usb_crc16_serial`: serial LFSR with `init` and `enable` inputs and a 16-bit state output.

## Test plan
- DATA0 (PID 8'hC3) with payload 8'h00 8'h01 8'h02 8'h03 plus CRC bytes from the bench model, `out_ready` = 1 → 4 bytes emitted in order, `pkt_done` with `is_data` = 1 and all errors 0.
- Zero-length DATA1 (8'h4B, 8'h00, 8'h00) → no bytes emitted, `pkt_done` with `crc_err` = 0 and `len_err` = 0.
- Same packet as the first with one payload bit flipped → 4 bytes emitted, `crc_err` = 1.
- ACK (8'hD2), then a PID of 8'hC2 → both give `is_data` = 0; the first has `pid_err` = 0, the second `pid_err` = 1; no bytes emitted.
- DATA0 with an EOP 3 bits into a byte → `len_err` = 1, `crc_err` = 0. Reset asserted mid-payload → outputs return to reset values and no `pkt_done` follows.
- 6-byte DATA0 with `out_ready` held 0 → first byte held, later bytes dropped, `overflow` = 1 at `pkt_done`.
